// File: rtl/rr_arb4way.sv
// Four-source round-robin arbiter with a valid/ready output handshake.
// Registered select/grant drive an external 4-way data mux; accepted beats are counted.
module rr_arb4way #(
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic [3:0]             req,
  input  logic                   outReady,
  output logic [1:0]             select,
  output logic [3:0]             grant,
  output logic                   outValid,
  output logic [COUNT_WIDTH-1:0] grantCount
);

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;

  logic             handshake;
  logic [IDX_W-1:0] base_idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [IDX_W-1:0] cand_idx;

  // Priority starts just after the base: the previous winner, or the beat being accepted now.
  always_comb begin
    handshake  = (state == HOLD) && outReady;
    base_idx   = handshake ? select : last_grant;
    pick_idx   = base_idx;
    pick_found = 1'b0;
    cand_idx   = base_idx;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand_idx = IDX_W'(base_idx + IDX_W'(k));
      if (!pick_found && req[cand_idx]) begin
        pick_idx   = cand_idx;
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      select     <= '0;
      grant      <= '0;
      outValid   <= 1'b0;
      grantCount <= '0;
      last_grant <= IDX_W'(NUM_SRC - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= HOLD;
            select   <= pick_idx;
            grant    <= 4'b0001 << pick_idx;
            outValid <= 1'b1;
          end
        end
        HOLD: begin
          // Without outReady the current beat is frozen, whatever req does.
          if (outReady) begin
            last_grant <= select;
            grantCount <= grantCount + COUNT_WIDTH'(1);
            if (pick_found) begin
              select <= pick_idx;
              grant  <= 4'b0001 << pick_idx;
            end else begin
              state    <= IDLE;
              grant    <= '0;
              outValid <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          outValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb4way.sv
// Bench for rr_arb4way: directed vector table, reset/wrap sequences, and
// randomized traffic against a rotation-order reference model with an 8-bit data mux.
module tb_rr_arb4way;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] select;
  logic [3:0] grant;
  logic       out_valid;
  logic [7:0] grant_count;

  logic [7:0] din [4];
  logic [7:0] mux_out;

  int checks;
  int errors;

  // reference model state
  bit       m_valid;
  int       m_sel;
  int       m_last;
  int       m_cnt;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       vld;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [24];

  rr_arb4way #(.COUNT_WIDTH(8)) dut (
    .clk        (clk),
    .resetN     (reset_n),
    .req        (req),
    .outReady   (out_ready),
    .select     (select),
    .grant      (grant),
    .outValid   (out_valid),
    .grantCount (grant_count)
  );

  assign mux_out = din[select];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_valid = 1'b0;
    m_sel   = 0;
    m_last  = 3;
    m_cnt   = 0;
  endfunction

  // First requester in the order base+1, base+2, base+3, base (mod 4); -1 if none.
  function automatic int rr_pick(input logic [3:0] r, input int base);
    int cand;
    for (int i = 1; i <= 4; i++) begin
      cand = (base + i) % 4;
      if (r[cand]) return cand;
    end
    return -1;
  endfunction

  function automatic void model_edge(input logic [3:0] r, input logic rdy);
    int p;
    if (!m_valid) begin
      p = rr_pick(r, m_last);
      if (p >= 0) begin
        m_valid = 1'b1;
        m_sel   = p;
      end
    end else if (rdy) begin
      m_last = m_sel;
      m_cnt  = (m_cnt + 1) % 256;
      p = rr_pick(r, m_sel);
      if (p >= 0) m_sel = p;
      else m_valid = 1'b0;
    end
  endfunction

  task automatic check_model(input string tag);
    logic [3:0] exp_gnt;
    exp_gnt = m_valid ? (4'b0001 << m_sel) : 4'b0000;
    chk({tag, "_select"}, 32'(select), 32'(m_sel));
    chk({tag, "_grant"},  32'(grant),  32'(exp_gnt));
    chk({tag, "_valid"},  32'(out_valid), 32'(m_valid));
    chk({tag, "_count"},  32'(grant_count), 32'(m_cnt));
    if (m_valid) chk({tag, "_mux"}, 32'(mux_out), 32'(din[m_sel]));
  endtask

  task automatic step(input logic [3:0] r, input logic rdy, input string tag);
    @(negedge clk);
    req       = r;
    out_ready = rdy;
    for (int d = 0; d < 4; d++) din[d] = 8'($urandom);
    model_edge(r, rdy);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    for (int d = 0; d < 4; d++) din[d] = 8'(d * 17);
    model_reset();

    // Full rotation, idle drop, held beat, skip-ahead, and sole-requester regrant.
    tbl[0]  = '{4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 8'd0};
    tbl[1]  = '{4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 8'd1};
    tbl[2]  = '{4'b1111, 1'b1, 2'd2, 4'b0100, 1'b1, 8'd2};
    tbl[3]  = '{4'b1111, 1'b1, 2'd3, 4'b1000, 1'b1, 8'd3};
    tbl[4]  = '{4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 8'd4};
    tbl[5]  = '{4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 8'd5};
    tbl[6]  = '{4'b1111, 1'b1, 2'd2, 4'b0100, 1'b1, 8'd6};
    tbl[7]  = '{4'b1111, 1'b1, 2'd3, 4'b1000, 1'b1, 8'd7};
    tbl[8]  = '{4'b0000, 1'b1, 2'd3, 4'b0000, 1'b0, 8'd8};
    tbl[9]  = '{4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 8'd8};
    tbl[10] = '{4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 8'd8};
    tbl[11] = '{4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 8'd8};
    tbl[12] = '{4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 8'd8};
    tbl[13] = '{4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 8'd8};
    tbl[14] = '{4'b0001, 1'b0, 2'd2, 4'b0100, 1'b1, 8'd8};
    tbl[15] = '{4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 8'd9};
    tbl[16] = '{4'b0010, 1'b1, 2'd1, 4'b0010, 1'b1, 8'd10};
    tbl[17] = '{4'b1010, 1'b1, 2'd3, 4'b1000, 1'b1, 8'd11};
    tbl[18] = '{4'b1010, 1'b1, 2'd1, 4'b0010, 1'b1, 8'd12};
    tbl[19] = '{4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 8'd13};
    tbl[20] = '{4'b0010, 1'b1, 2'd1, 4'b0010, 1'b1, 8'd13};
    tbl[21] = '{4'b0010, 1'b1, 2'd1, 4'b0010, 1'b1, 8'd14};
    tbl[22] = '{4'b0000, 1'b0, 2'd1, 4'b0010, 1'b1, 8'd14};
    tbl[23] = '{4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 8'd15};

    #12;
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_grant",  32'(grant),  32'd0);
    chk("rst_valid",  32'(out_valid), 32'd0);
    chk("rst_count",  32'(grant_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      req       = tbl[i].req;
      out_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_select", i), 32'(select), 32'(tbl[i].sel));
      chk($sformatf("vec%0d_grant", i),  32'(grant),  32'(tbl[i].gnt));
      chk($sformatf("vec%0d_valid", i),  32'(out_valid), 32'(tbl[i].vld));
      chk($sformatf("vec%0d_count", i),  32'(grant_count), 32'(tbl[i].cnt));
    end

    // Grant C, then reset asynchronously in the middle of the held beat.
    @(negedge clk);
    req       = 4'b0100;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_c_select", 32'(select), 32'd2);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_select", 32'(select), 32'd0);
    chk("async_rst_grant",  32'(grant),  32'd0);
    chk("async_rst_valid",  32'(out_valid), 32'd0);
    chk("async_rst_count",  32'(grant_count), 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_select", 32'(select), 32'd0);
    chk("post_rst_grant",  32'(grant),  32'd1);
    chk("post_rst_count",  32'(grant_count), 32'd0);

    // 256 accepted beats wrap the counter back to zero.
    do_reset();
    for (int i = 0; i < 257; i++) step(4'b1111, 1'b1, "wrap");
    chk("wrap_count_zero", 32'(grant_count), 32'd0);
    step(4'b0000, 1'b1, "wrap_drain");

    // Randomized traffic, occasionally idle, with ready stalls.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r;
      logic       rdy;
      r   = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      step(r, rdy, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
